// File: rtl/fifo_pkg.sv
// Shared FIFO constants: default word/address widths and the depth helper.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered synchronous read (1-cycle latency).
// No flow control of its own; enables are qualified by the caller.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_dat,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_dat
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_dat;

  // Array itself is never reset so it can map onto block or distributed RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_dat <= '0;
    end else if (i_rd_en) begin
      r_rd_dat <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with level and sticky error flags; dout valid the cycle after an accepted read.
// Writes while full and reads while empty are dropped and latch overflow/underflow until rst.
module async_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int PW    = ADDR_WIDTH + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_overflow;
  logic          r_underflow;

  logic [PW-1:0] w_occ;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  // Extra wrap bit makes the modular difference span 0..DEPTH unambiguously.
  assign w_occ    = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_occ == PW'(DEPTH));
  assign w_empty  = (w_occ == '0);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (wr_en && w_full)  r_overflow  <= 1'b1;
      if (rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (w_wr_acc && !rst),
    .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wr_dat  (din),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_dat  (dout)
  );

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_occ >= PW'(AF_LEVEL));
  assign almost_empty = (w_occ <= PW'(AE_LEVEL));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: vector table for fill/overflow/drain/underflow, hand sequences for wrap and reset.
module tb_async_fifo;
  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  async_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // status = {empty, almost_empty, full, almost_full, overflow, underflow}
  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [5:0] st;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] st_of(input int occ, input logic ov, input logic un);
    return {occ == 0, occ <= 1, occ == 8, occ >= 7, ov, un};
  endfunction

  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] est, input logic [7:0] edout);
    logic [5:0] ast;
    ast = {empty, almost_empty, full, almost_full, overflow, underflow};
    checks++;
    if (ast !== est) begin
      errors++;
      $display("FAIL %s status {e,ae,f,af,ov,un} got %b expected %b", name, ast, est);
    end
    checks++;
    if (dout !== edout) begin
      errors++;
      $display("FAIL %s dout got %h expected %h", name, dout, edout);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;

    // reset (2 cycles)
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'd0,  6'b110000, 8'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'd0,  6'b110000, 8'd0});
    // fill 10..80
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd10, 6'b010000, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd20, 6'b000000, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd30, 6'b000000, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd40, 6'b000000, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd50, 6'b000000, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd60, 6'b000000, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd70, 6'b000100, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd80, 6'b001100, 8'd0});
    // overflow attempt, then idle to show it sticks
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'd90, 6'b001110, 8'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  6'b001110, 8'd0});
    // drain
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0,  6'b000110, 8'd10});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0,  6'b000010, 8'd20});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0,  6'b000010, 8'd30});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0,  6'b000010, 8'd40});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0,  6'b000010, 8'd50});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0,  6'b000010, 8'd60});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0,  6'b010010, 8'd70});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0,  6'b110010, 8'd80});
    // underflow attempt, then idle
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'd0,  6'b110011, 8'd80});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'd0,  6'b110011, 8'd80});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].dout);
    end

    // three words stored, then 10 cycles of simultaneous read+write across the wrap
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'hA1 + 8'(i));
      q.push_back(8'hA1 + 8'(i));
      check($sformatf("pre%0d", i), st_of(i + 1, 1'b1, 1'b1), 8'd80);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'hB0 + 8'(i));
      q.push_back(8'hB0 + 8'(i));
      exp_d = q.pop_front();
      check($sformatf("wrap%0d", i), st_of(3, 1'b1, 1'b1), exp_d);
    end

    // reset mid-operation
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    check("midrst", st_of(0, 1'b0, 1'b0), 8'd0);

    // simultaneous access while empty: write wins, read flags underflow
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    check("empty_wr_rd", st_of(1, 1'b0, 1'b1), 8'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("empty_rd_back", st_of(0, 1'b0, 1'b1), 8'h5A);

    // refill, then simultaneous access while full: read wins, write flags overflow
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'hC0 + 8'(i));
      check($sformatf("refill%0d", i), st_of(i + 1, 1'b0, 1'b1), 8'h5A);
    end
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    check("full_wr_rd", st_of(7, 1'b1, 1'b1), 8'hC0);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check($sformatf("final%0d", i), st_of(7 - i, 1'b1, 1'b1), 8'hC0 + 8'(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
